modbus_rtu_rx: RTL and testbench
================================

Name: modbus_rtu_rx

Overview:
Modbus-RTU request receiver for a slave node. Deserialises an asynchronous UART line (8N1) and collects bytes into a frame buffer. An inter-byte silence of TIMER_OUT clocks delimits each frame. Once a frame closes, it checks CRC-16/MODBUS, decodes an 8-byte read-style request (address, function, register start, register count) and reports the result to downstream register-access logic.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (434 at defaults)
TIMER_OUT, 200000, idle clocks that end a frame (4 ms at 50 MHz); benches override to 10000

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-high (reset applied on a clk edge while rst_n=1)
uart_rx_wire  in  1  serial input, idle high, LSB first
frame_done  out  1  one-cycle pulse when a frame closes
frame_len  out  4  bytes received in the frame, saturating at 15
dev_addr  out  8  byte 0
func_code  out  8  byte 1
reg_addr  out  16  {byte2,byte3}
reg_num  out  16  {byte4,byte5}
crc_rx  out  16  {byte7,byte6} (wire order is low byte first)
crc_ok  out  1  CRC over bytes 0..5 equals crc_rx and frame_len==8
frame_err  out  1  frame_len!=8, or a stop-bit error occurred in the frame

Behaviour:
- Reset: all outputs 0; RX FSM IDLE; byte count 0; CRC register 0xFFFF; timer cleared; buffer cleared.
- Input sync: 2-FF synchroniser on uart_rx_wire. A falling edge of the synchronised signal in IDLE starts a byte.
- RX FSM states:
  - IDLE -> START: on falling edge.
  - START: wait BAUD_DIV/2 clocks, resample. If the line is high, treat as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits at BAUD_DIV intervals, LSB first, then go to STOP.
  - STOP: sample after BAUD_DIV. A high sample means byte valid (rx_done, 1 cycle). A low sample sets the sticky per-frame error flag and discards the byte. Return to IDLE.
- Frame buffer:
  - On rx_done, if count<8, store the byte at index count.
  - count increments saturating at 15. Bytes beyond 8 are dropped but counted.
- CRC:
  - CRC-16/MODBUS: init 0xFFFF, reflected poly 0xA001, no final XOR.
  - Updated on rx_done for bytes with index 0..5 only. A byte-wise combinational or 8-cycle serial update is allowed, provided it completes before the next rx_done.
- Timer:
  - Cleared on START entry and on rx_done.
  - Increments each clock while the RX FSM is IDLE and count>0.
  - When it reaches TIMER_OUT-1, the frame closes.
- Frame close (next cycle):
  - frame_done=1 for exactly one cycle.
  - frame_len, dev_addr, func_code, reg_addr, reg_num, crc_rx, crc_ok and frame_err are updated in the same cycle and hold until the next frame_done.
  - Then count<=0, CRC<=0xFFFF, error flag<=0, timer<=0.
- Missing buffer entries for short frames read as 0x00.
- A zero-byte idle period never produces frame_done.
- A start bit arriving during the same cycle as frame close belongs to the new frame.
- Reset mid-byte or mid-frame: partial data is discarded, no frame_done is emitted, and outputs go to 0.

Test Plan:
1. Send 01 03 00 01 00 02 95 CB at 115200, then idle ≥TIMER_OUT -> one frame_done pulse about TIMER_OUT clocks after the last stop bit. Expect frame_len=8, dev_addr=0x01, func_code=0x03, reg_addr=0x0001, reg_num=0x0002, crc_rx=0xCB95, crc_ok=1, frame_err=0.
2. Send 01 03 00 01 00 02 00 00 with TIMER_OUT=10000 -> same fields, crc_rx=0x0000, crc_ok=0, frame_err=0.
3. Send 3 bytes 01 03 00, then idle -> frame_len=3, frame_err=1, crc_ok=0, reg_addr=0x0000.
4. Send 10 back-to-back bytes (valid 8-byte frame plus 2 extra) -> frame_len=10, frame_err=1, crc_ok=0, and fields reflect the first 8 bytes.
5. Send two valid frames separated by a gap > TIMER_OUT -> two frame_done pulses with independent results, CRC reinitialised. A gap < TIMER_OUT merges them into frame_len=15 (saturated) with frame_err=1.
6. Assert rst_n=1 after byte 4 of a frame, release, then send a full valid frame -> no frame_done for the aborted frame. The following frame decodes with crc_ok=1. A forced stop-bit=0 byte in a frame yields frame_err=1.

Source files
------------

// File: rtl/modbus_rtu_rx.sv
// Modbus-RTU request receiver: 8N1 UART deserialiser, silence-delimited frame buffer,
// CRC-16/MODBUS check and decode of an 8-byte read-style request.
module modbus_rtu_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int TIMER_OUT = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_wire,
    output logic        frame_done,
    output logic [3:0]  frame_len,
    output logic [7:0]  dev_addr,
    output logic [7:0]  func_code,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_num,
    output logic [15:0] crc_rx,
    output logic        crc_ok,
    output logic        frame_err
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW       = (TIMER_OUT > 1) ? $clog2(TIMER_OUT) : 1;
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TIME_END = TW'(TIMER_OUT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t       state_r, state_next_s;
    logic            rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0]   baud_cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            baud_tick_s, fall_s, start_s, rx_done_s, stop_err_s, close_s;
    logic [3:0]      count_r;
    logic [7:0]      frame_buf_r [8];
    logic [15:0]     crc_r;
    logic            err_r;
    logic [TW-1:0]   timer_r;

    // Reflected-polynomial CRC update, one byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign fall_s  = rx_prev_r & ~rx_sync_r;
    assign start_s = (state_r == IDLE) && fall_s;
    assign close_s = (state_r == IDLE) && (count_r != 4'd0) && (timer_r == TIME_END);

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // RX next-state, bit-sampling strobe and byte result strobes.
    always_comb begin
        state_next_s = state_r;
        baud_tick_s  = 1'b0;
        rx_done_s    = 1'b0;
        stop_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                baud_tick_s = (baud_cnt_r == HALF_END);
                if (baud_tick_s) begin
                    state_next_s = rx_sync_r ? IDLE : DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                baud_tick_s = (baud_cnt_r == BIT_END);
                if (baud_tick_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                baud_tick_s = (baud_cnt_r == BIT_END);
                if (baud_tick_s) begin
                    state_next_s = IDLE;
                    rx_done_s    = rx_sync_r;
                    stop_err_s   = ~rx_sync_r;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Line synchroniser, baud counter and data shift register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            rx_meta_r <= uart_rx_wire;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            if ((state_r == IDLE) || baud_tick_s) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + 1'b1;
            end
            if (state_r != DATA) begin
                bit_idx_r <= 3'd0;
            end else if (baud_tick_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
                shift_r   <= {rx_sync_r, shift_r[7:1]};
            end
        end
    end

    // Frame collection, silence timer and result publication on close.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count_r    <= 4'd0;
            crc_r      <= 16'hFFFF;
            err_r      <= 1'b0;
            timer_r    <= '0;
            for (int i = 0; i < 8; i++) frame_buf_r[i] <= 8'h00;
            frame_done <= 1'b0;
            frame_len  <= 4'd0;
            dev_addr   <= 8'h00;
            func_code  <= 8'h00;
            reg_addr   <= 16'h0000;
            reg_num    <= 16'h0000;
            crc_rx     <= 16'h0000;
            crc_ok     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= close_s;
            if (close_s) begin
                frame_len <= count_r;
                dev_addr  <= frame_buf_r[0];
                func_code <= frame_buf_r[1];
                reg_addr  <= {frame_buf_r[2], frame_buf_r[3]};
                reg_num   <= {frame_buf_r[4], frame_buf_r[5]};
                crc_rx    <= {frame_buf_r[7], frame_buf_r[6]};
                crc_ok    <= (count_r == 4'd8) && (crc_r == {frame_buf_r[7], frame_buf_r[6]});
                frame_err <= (count_r != 4'd8) || err_r;
                count_r   <= 4'd0;
                crc_r     <= 16'hFFFF;
                err_r     <= 1'b0;
                timer_r   <= '0;
                // Cleared so that short frames report absent bytes as zero.
                for (int i = 0; i < 8; i++) frame_buf_r[i] <= 8'h00;
            end else begin
                if (rx_done_s) begin
                    if (count_r < 4'd8) frame_buf_r[count_r[2:0]] <= shift_r;
                    if (count_r != 4'd15) count_r <= count_r + 4'd1;
                    if (count_r < 4'd6) crc_r <= crc16_byte(crc_r, shift_r);
                end
                if (stop_err_s) err_r <= 1'b1;
                if (start_s || rx_done_s) begin
                    timer_r <= '0;
                end else if ((state_r == IDLE) && (count_r != 4'd0)) begin
                    timer_r <= timer_r + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_modbus_rtu_rx.sv
// Directed bench for modbus_rtu_rx: hand-built serial frames with hand-computed results.
module tb_modbus_rtu_rx;
    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD      = 100_000;
    localparam int TIMER_OUT = 300;
    localparam int BD        = CLK_FREQ / BAUD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx_wire;
    logic        frame_done;
    logic [3:0]  frame_len;
    logic [7:0]  dev_addr, func_code;
    logic [15:0] reg_addr, reg_num, crc_rx;
    logic        crc_ok, frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    modbus_rtu_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMER_OUT(TIMER_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx_wire(uart_rx_wire),
        .frame_done(frame_done), .frame_len(frame_len), .dev_addr(dev_addr),
        .func_code(func_code), .reg_addr(reg_addr), .reg_num(reg_num),
        .crc_rx(crc_rx), .crc_ok(crc_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx_wire = 1'b0;
        repeat (BD) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_wire = b[i];
            repeat (BD) @(posedge clk);
        end
        uart_rx_wire = stop_bit;
        repeat (BD) @(posedge clk);
        uart_rx_wire = 1'b1;
        if (!stop_bit) repeat (BD) @(posedge clk);
    endtask

    // First byte on the wire sits in the top byte of data.
    task automatic send_bytes(input logic [127:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(data[127-8*i -: 8], 1'b1);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [3:0] len, input logic [7:0] da,
                                input logic [7:0] fc, input logic [15:0] ra, input logic [15:0] rn,
                                input logic [15:0] cr, input logic ok, input logic err,
                                output int lat);
        logic found;
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < TIMER_OUT + 4 * BD; i++) begin
            @(negedge clk);
            if (frame_done) begin
                found = 1'b1;
                break;
            end
            lat++;
        end
        check({tag, "_done"}, 32'(found), 32'd1);
        if (found) begin
            check({tag, "_len"},  32'(frame_len), 32'(len));
            check({tag, "_dev"},  32'(dev_addr),  32'(da));
            check({tag, "_func"}, 32'(func_code), 32'(fc));
            check({tag, "_reg"},  32'(reg_addr),  32'(ra));
            check({tag, "_num"},  32'(reg_num),   32'(rn));
            check({tag, "_crc"},  32'(crc_rx),    32'(cr));
            check({tag, "_ok"},   32'(crc_ok),    32'(ok));
            check({tag, "_err"},  32'(frame_err), 32'(err));
            @(negedge clk);
            check({tag, "_pulse"}, 32'(frame_done), 32'd0);
            check({tag, "_hold"},  32'(frame_len),  32'(len));
        end
    endtask

    localparam logic [127:0] FRAME_A = 128'h01030001000295CB_0000000000000000;
    localparam logic [127:0] FRAME_B = 128'h1103006B00037687_0000000000000000;
    localparam logic [127:0] FRAME_Z = 128'h0103000100020000_0000000000000000;
    localparam logic [127:0] FRAME_X = 128'h01030001000295CBAA55000000000000;

    initial begin
        int lat;
        int cnt_before;
        rst_n        = 1'b1;
        uart_rx_wire = 1'b1;
        repeat (5) @(posedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_outs", 32'({frame_done, frame_len, crc_ok, frame_err}), 32'd0);
        check("rst_fields", 32'(dev_addr | func_code | reg_addr | reg_num | crc_rx), 32'd0);
        repeat (TIMER_OUT + 20) @(posedge clk);
        check("idle_no_frame", 32'(done_cnt), 32'd0);

        // Valid request; close roughly TIMER_OUT clocks after the last stop bit.
        send_bytes(FRAME_A, 8);
        expect_frame("t1", 4'd8, 8'h01, 8'h03, 16'h0001, 16'h0002, 16'hCB95, 1'b1, 1'b0, lat);
        check("t1_lat", 32'((lat > TIMER_OUT - 2 * BD) && (lat < TIMER_OUT + 2 * BD)), 32'd1);

        send_bytes(FRAME_Z, 8);
        expect_frame("t2", 4'd8, 8'h01, 8'h03, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, lat);

        send_bytes(FRAME_A, 3);
        expect_frame("t3", 4'd3, 8'h01, 8'h03, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, lat);

        send_bytes(FRAME_X, 10);
        expect_frame("t4", 4'd10, 8'h01, 8'h03, 16'h0001, 16'h0002, 16'hCB95, 1'b0, 1'b1, lat);

        // Two separated frames, then the same pair merged by a short gap.
        send_bytes(FRAME_A, 8);
        expect_frame("t5a", 4'd8, 8'h01, 8'h03, 16'h0001, 16'h0002, 16'hCB95, 1'b1, 1'b0, lat);
        repeat (50) @(posedge clk);
        send_bytes(FRAME_B, 8);
        expect_frame("t5b", 4'd8, 8'h11, 8'h03, 16'h006B, 16'h0003, 16'h8776, 1'b1, 1'b0, lat);
        send_bytes(FRAME_A, 8);
        repeat (150) @(posedge clk);
        send_bytes(FRAME_B, 8);
        expect_frame("t5m", 4'd15, 8'h01, 8'h03, 16'h0001, 16'h0002, 16'hCB95, 1'b0, 1'b1, lat);

        // Reset after four bytes: nothing is reported for the aborted frame.
        cnt_before = done_cnt;
        send_bytes(FRAME_A, 4);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_len", 32'(frame_len), 32'd0);
        check("t6_rst_dev", 32'(dev_addr), 32'd0);
        repeat (TIMER_OUT + 50) @(posedge clk);
        check("t6_no_frame", 32'(done_cnt), 32'(cnt_before));
        send_bytes(FRAME_B, 8);
        expect_frame("t6v", 4'd8, 8'h11, 8'h03, 16'h006B, 16'h0003, 16'h8776, 1'b1, 1'b0, lat);

        // A byte with a low stop bit is discarded but flags the frame.
        send_bytes(FRAME_A, 3);
        send_byte(8'hFF, 1'b0);
        send_bytes(FRAME_A << 24, 5);
        expect_frame("t6e", 4'd8, 8'h01, 8'h03, 16'h0001, 16'h0002, 16'hCB95, 1'b1, 1'b1, lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
